// File: rtl/ap_ctrl_profiler_pkg.sv
// ap_ctrl_profiler_pkg: shared types and helpers for the ap_ctrl handshake profiler
package ap_ctrl_profiler_pkg;

    typedef enum logic [2:0] {
        SEL_STARTS,
        SEL_DONES,
        SEL_LAST_LAT,
        SEL_MIN_LAT,
        SEL_MAX_LAT,
        SEL_LAST_II,
        SEL_STALL,
        SEL_BLOCKED
    } stat_sel_e;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        BLOCKED
    } ch_state_e;

    // increments v, sticking at the all-ones value of a w-bit field (w <= 64)
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
        logic [63:0] top;
        top = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return (v >= top) ? v : v + 64'd1;
    endfunction

endpackage

// File: rtl/ap_ctrl_ch_profiler.sv
// ap_ctrl_ch_profiler: one channel's timestamp FIFO, state, statistics and error flags
module ap_ctrl_ch_profiler
    import ap_ctrl_profiler_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int TS_W        = 32,
    parameter int OUTSTANDING = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             hold,
    input  logic [TS_W-1:0]  ts,
    input  logic             ap_start,
    input  logic             ap_ready,
    input  logic             ap_done,
    input  logic             ap_continue,
    output logic [CNT_W-1:0] starts,
    output logic [CNT_W-1:0] dones,
    output logic [TS_W-1:0]  last_lat,
    output logic [TS_W-1:0]  min_lat,
    output logic [TS_W-1:0]  max_lat,
    output logic [TS_W-1:0]  last_ii,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] blocked_cnt,
    output logic             ovf_flag,
    output logic             unf_flag
);

    localparam int AW = $clog2(OUTSTANDING);

    logic [TS_W-1:0] fifo [OUTSTANDING];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     occ;
    logic [TS_W-1:0] prev_ts;
    logic            have_prev;
    ch_state_e       state_q, state_d;

    logic start_ev, done_ev, empty, full, bypass, pop, push, done_cnt, ovf_ev, unf_ev;
    logic [TS_W-1:0] lat;

    // a simultaneous start and done on an empty FIFO is a zero-latency pass-through
    always_comb begin
        start_ev = ap_start & ap_ready;
        done_ev  = ap_done & ap_continue;
        empty    = occ == '0;
        full     = occ == (AW+1)'(OUTSTANDING);
        bypass   = start_ev & done_ev & empty;
        pop      = done_ev & ~empty;
        push     = start_ev & ~bypass & (~full | pop);
        done_cnt = pop | bypass;
        ovf_ev   = start_ev & full & ~done_ev;
        unf_ev   = done_ev & empty & ~start_ev;
        lat      = bypass ? '0 : ts - fifo[rd_ptr];
    end

    always_comb begin
        state_d = (ap_done & ~ap_continue) ? BLOCKED : (empty ? IDLE : BUSY);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            occ         <= '0;
            prev_ts     <= '0;
            have_prev   <= 1'b0;
            starts      <= '0;
            dones       <= '0;
            last_lat    <= '0;
            min_lat     <= '1;
            max_lat     <= '0;
            last_ii     <= '0;
            stall_cnt   <= '0;
            blocked_cnt <= '0;
            ovf_flag    <= 1'b0;
            unf_flag    <= 1'b0;
        end else if (!hold) begin
            state_q <= state_d;
            if (push) begin
                fifo[wr_ptr] <= ts;
                wr_ptr       <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            occ <= occ + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            if (start_ev) begin
                starts    <= CNT_W'(sat_inc(64'(starts), CNT_W));
                prev_ts   <= ts;
                have_prev <= 1'b1;
                if (have_prev)
                    last_ii <= ts - prev_ts;
            end
            if (done_cnt) begin
                dones    <= CNT_W'(sat_inc(64'(dones), CNT_W));
                last_lat <= lat;
                if (lat < min_lat)
                    min_lat <= lat;
                if (lat > max_lat)
                    max_lat <= lat;
            end
            if (ap_start & ~ap_ready)
                stall_cnt <= CNT_W'(sat_inc(64'(stall_cnt), CNT_W));
            if (state_q == BLOCKED)
                blocked_cnt <= CNT_W'(sat_inc(64'(blocked_cnt), CNT_W));
            ovf_flag <= ovf_flag | ovf_ev;
            unf_flag <= unf_flag | unf_ev;
        end
    end

endmodule

// File: rtl/ap_ctrl_profiler.sv
// ap_ctrl_profiler: multi-channel ap_ctrl_hs/ap_ctrl_chain handshake profiler with registered read port
module ap_ctrl_profiler
    import ap_ctrl_profiler_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 32,
    parameter int TS_W        = 32,
    parameter int OUTSTANDING = 4,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              finish,
    input  logic [NUM_CH-1:0] ap_start,
    input  logic [NUM_CH-1:0] ap_ready,
    input  logic [NUM_CH-1:0] ap_done,
    input  logic [NUM_CH-1:0] ap_continue,
    input  logic              rd_en,
    input  logic [CH_W-1:0]   rd_ch,
    input  logic [2:0]        rd_sel,
    output logic              rd_valid,
    output logic [CNT_W-1:0]  rd_data,
    output logic [NUM_CH-1:0] ovf_flag,
    output logic [NUM_CH-1:0] unf_flag,
    output logic              frozen
);

    logic [TS_W-1:0]  ts;
    logic [CNT_W-1:0] starts      [NUM_CH];
    logic [CNT_W-1:0] dones       [NUM_CH];
    logic [TS_W-1:0]  last_lat    [NUM_CH];
    logic [TS_W-1:0]  min_lat     [NUM_CH];
    logic [TS_W-1:0]  max_lat     [NUM_CH];
    logic [TS_W-1:0]  last_ii     [NUM_CH];
    logic [CNT_W-1:0] stall_cnt   [NUM_CH];
    logic [CNT_W-1:0] blocked_cnt [NUM_CH];
    logic [CNT_W-1:0] rd_mux;

    always_ff @(posedge clock) begin
        if (reset) begin
            ts     <= '0;
            frozen <= 1'b0;
        end else begin
            if (!frozen)
                ts <= ts + 1'b1;
            if (finish)
                frozen <= 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        ap_ctrl_ch_profiler #(
            .CNT_W       (CNT_W),
            .TS_W        (TS_W),
            .OUTSTANDING (OUTSTANDING)
        ) u_ch (
            .clock       (clock),
            .reset       (reset),
            .hold        (frozen),
            .ts          (ts),
            .ap_start    (ap_start[g]),
            .ap_ready    (ap_ready[g]),
            .ap_done     (ap_done[g]),
            .ap_continue (ap_continue[g]),
            .starts      (starts[g]),
            .dones       (dones[g]),
            .last_lat    (last_lat[g]),
            .min_lat     (min_lat[g]),
            .max_lat     (max_lat[g]),
            .last_ii     (last_ii[g]),
            .stall_cnt   (stall_cnt[g]),
            .blocked_cnt (blocked_cnt[g]),
            .ovf_flag    (ovf_flag[g]),
            .unf_flag    (unf_flag[g])
        );
    end

    // unmatched channel numbers fall through to zero
    always_comb begin
        rd_mux = '0;
        for (int c = 0; c < NUM_CH; c++)
            if (rd_ch == CH_W'(c))
                case (stat_sel_e'(rd_sel))
                    SEL_STARTS:   rd_mux = starts[c];
                    SEL_DONES:    rd_mux = dones[c];
                    SEL_LAST_LAT: rd_mux = CNT_W'(last_lat[c]);
                    SEL_MIN_LAT:  rd_mux = CNT_W'(min_lat[c]);
                    SEL_MAX_LAT:  rd_mux = CNT_W'(max_lat[c]);
                    SEL_LAST_II:  rd_mux = CNT_W'(last_ii[c]);
                    SEL_STALL:    rd_mux = stall_cnt[c];
                    default:      rd_mux = blocked_cnt[c];
                endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en)
                rd_data <= rd_mux;
        end
    end

endmodule

// File: tb/tb_ap_ctrl_profiler.sv
// tb_ap_ctrl_profiler: directed-vector bench for ap_ctrl_profiler with hand-computed expectations
module tb_ap_ctrl_profiler;

    localparam int NUM_CH = 3;

    logic              clock = 1'b0;
    logic              reset, finish, rd_en, rd_valid, frozen;
    logic [NUM_CH-1:0] ap_start, ap_ready, ap_done, ap_continue, ovf_flag, unf_flag;
    logic [1:0]        rd_ch;
    logic [2:0]        rd_sel;
    logic [31:0]       rd_data;
    logic [15:0]       sm, dm;
    int                checks = 0;
    int                failures = 0;

    ap_ctrl_profiler #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (32),
        .TS_W        (32),
        .OUTSTANDING (4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .finish      (finish),
        .ap_start    (ap_start),
        .ap_ready    (ap_ready),
        .ap_done     (ap_done),
        .ap_continue (ap_continue),
        .rd_en       (rd_en),
        .rd_ch       (rd_ch),
        .rd_sel      (rd_sel),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .ovf_flag    (ovf_flag),
        .unf_flag    (unf_flag),
        .frozen      (frozen)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic rd_chk(input string tag, input int ch, input int sel, input logic [31:0] exp);
        rd_en  = 1'b1;
        rd_ch  = 2'(ch);
        rd_sel = 3'(sel);
        tick();
        rd_en = 1'b0;
        check({tag, "_valid"}, 64'(rd_valid), 64'd1);
        check(tag, 64'(rd_data), 64'(exp));
    endtask

    initial begin
        reset = 1'b1; finish = 1'b0; rd_en = 1'b0; rd_ch = '0; rd_sel = '0;
        ap_start = '0; ap_ready = '0; ap_done = '0; ap_continue = '1;
        repeat (2) tick();
        reset = 1'b0;
        check("rst_frozen", 64'(frozen), 64'd0);
        check("rst_ovf", 64'(ovf_flag), 64'd0);
        check("rst_unf", 64'(unf_flag), 64'd0);
        check("rst_rd_valid", 64'(rd_valid), 64'd0);
        check("rst_rd_data", 64'(rd_data), 64'd0);
        rd_chk("rst_min_ch2", 2, 3, 32'hFFFF_FFFF);
        rd_chk("rst_starts_ch0", 0, 0, 32'd0);
        tick();
        check("rd_valid_drop", 64'(rd_valid), 64'd0);

        // ch0: single transaction, latency 5
        ap_start[0] = 1'b1; ap_ready[0] = 1'b1; tick();
        ap_start[0] = 1'b0; ap_ready[0] = 1'b0; repeat (4) tick();
        ap_done[0] = 1'b1; tick();
        ap_done[0] = 1'b0;
        rd_chk("c0_starts", 0, 0, 32'd1);
        rd_chk("c0_dones", 0, 1, 32'd1);
        rd_chk("c0_last", 0, 2, 32'd5);
        rd_chk("c0_min", 0, 3, 32'd5);
        rd_chk("c0_max", 0, 4, 32'd5);

        // ch1: pipelined starts at 0,2,4 and dones at 10,13,15
        sm = 16'b0000_0000_0001_0101;
        dm = 16'b1010_0100_0000_0000;
        for (int k = 0; k < 16; k++) begin
            ap_start[1] = sm[k]; ap_ready[1] = sm[k]; ap_done[1] = dm[k];
            tick();
        end
        ap_start[1] = 1'b0; ap_ready[1] = 1'b0; ap_done[1] = 1'b0;
        rd_chk("c1_starts", 1, 0, 32'd3);
        rd_chk("c1_dones", 1, 1, 32'd3);
        rd_chk("c1_last", 1, 2, 32'd11);
        rd_chk("c1_min", 1, 3, 32'd10);
        rd_chk("c1_max", 1, 4, 32'd11);
        rd_chk("c1_ii", 1, 5, 32'd2);
        check("c1_flags", 64'({ovf_flag, unf_flag}), 64'd0);

        // ch2: 3 stall cycles, then 4 blocked cycles before done
        ap_start[2] = 1'b1; ap_ready[2] = 1'b0; repeat (3) tick();
        ap_ready[2] = 1'b1; tick();
        ap_start[2] = 1'b0; ap_ready[2] = 1'b0;
        ap_done[2] = 1'b1; ap_continue[2] = 1'b0; repeat (4) tick();
        ap_continue[2] = 1'b1; tick();
        ap_done[2] = 1'b0;
        rd_chk("c2_stall", 2, 6, 32'd3);
        rd_chk("c2_blocked", 2, 7, 32'd4);
        rd_chk("c2_last", 2, 2, 32'd5);

        // ch0 overflow: 5 starts into a 4-deep FIFO
        ap_start[0] = 1'b1; ap_ready[0] = 1'b1; repeat (5) tick();
        ap_start[0] = 1'b0; ap_ready[0] = 1'b0;
        check("ovf_flag", 64'(ovf_flag), 64'b001);
        rd_chk("ovf_starts", 0, 0, 32'd6);

        // ch1 underflow: done with nothing outstanding
        ap_done[1] = 1'b1; tick();
        ap_done[1] = 1'b0;
        check("unf_flag", 64'(unf_flag), 64'b010);
        rd_chk("unf_dones", 1, 1, 32'd3);
        rd_chk("unf_last", 1, 2, 32'd11);

        // ch2 same-cycle start+done: bypass when empty, pop+push with one outstanding
        ap_start[2] = 1'b1; ap_ready[2] = 1'b1; ap_done[2] = 1'b1; tick();
        ap_start[2] = 1'b0; ap_ready[2] = 1'b0; ap_done[2] = 1'b0;
        rd_chk("byp_last", 2, 2, 32'd0);
        rd_chk("byp_min", 2, 3, 32'd0);
        ap_start[2] = 1'b1; ap_ready[2] = 1'b1; tick();
        ap_start[2] = 1'b0; ap_ready[2] = 1'b0; repeat (2) tick();
        ap_start[2] = 1'b1; ap_ready[2] = 1'b1; ap_done[2] = 1'b1; tick();
        ap_start[2] = 1'b0; ap_ready[2] = 1'b0; ap_done[2] = 1'b0;
        rd_chk("swap_last", 2, 2, 32'd3);
        ap_done[2] = 1'b1; tick();
        ap_done[2] = 1'b0;
        rd_chk("swap_tail_last", 2, 2, 32'd2);
        rd_chk("swap_dones", 2, 1, 32'd4);
        rd_chk("swap_starts", 2, 0, 32'd4);
        rd_chk("swap_max", 2, 4, 32'd5);
        check("swap_flags", 64'({ovf_flag, unf_flag}), 64'b001_010);

        // freeze, then handshakes that must be ignored
        finish = 1'b1; tick();
        finish = 1'b0;
        check("frozen", 64'(frozen), 64'd1);
        ap_done[0] = 1'b1; tick();
        ap_done[0] = 1'b0;
        ap_start[1] = 1'b1; ap_ready[1] = 1'b1; tick();
        ap_start[1] = 1'b0; ap_ready[1] = 1'b0;
        ap_done[2] = 1'b1; tick();
        ap_done[2] = 1'b0;
        rd_chk("frz_c0_dones", 0, 1, 32'd1);
        rd_chk("frz_c1_starts", 1, 0, 32'd3);
        check("frz_flags", 64'({ovf_flag, unf_flag}), 64'b001_010);
        rd_chk("bad_ch", 3, 0, 32'd0);
        tick();
        check("hold_valid", 64'(rd_valid), 64'd0);
        check("hold_data", 64'(rd_data), 64'd0);
        check("frozen_sticky", 64'(frozen), 64'd1);

        // mid-run reset discards in-flight ch0 timestamps
        reset = 1'b1; tick();
        reset = 1'b0;
        check("rst2_frozen", 64'(frozen), 64'd0);
        check("rst2_flags", 64'({ovf_flag, unf_flag}), 64'd0);
        rd_chk("rst2_min_ch2", 2, 3, 32'hFFFF_FFFF);
        rd_chk("rst2_c1_starts", 1, 0, 32'd0);
        rd_chk("rst2_c2_blocked", 2, 7, 32'd0);
        ap_start[0] = 1'b1; ap_ready[0] = 1'b1; tick();
        ap_start[0] = 1'b0; ap_ready[0] = 1'b0; tick();
        ap_done[0] = 1'b1; tick();
        ap_done[0] = 1'b0;
        rd_chk("rst2_c0_last", 0, 2, 32'd2);
        rd_chk("rst2_c0_dones", 0, 1, 32'd1);
        check("rst2_unf", 64'(unf_flag), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
